// File: rtl/bcd_counter_cascade.sv
// rtl/bcd_counter_cascade.sv - cascaded modulo-N digit counter with up/down, load, wrap/saturate
// Digits ripple carry/borrow combinationally within one clock; digit k sits at count[4k+3:4k].
module bcd_counter_cascade #(
    parameter int DIGITS  = 4,
    parameter int MODULUS = 10,
    parameter int WRAP    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   count,
    output logic                  rollover,
    output logic                  at_max,
    output logic                  at_zero
);

    localparam logic [3:0] MAX_DIGIT = 4'(MODULUS - 1);

    logic [4*DIGITS-1:0] r_count;
    logic                r_rollover;
    logic [4*DIGITS-1:0] w_stepped;
    logic [4*DIGITS-1:0] w_load;
    logic                w_boundary;
    logic                w_at_max;

    // A step is passed up the chain while every lower digit sits at its end value;
    // the chain falling off the top digit is exactly an overflow/underflow.
    always_comb begin
        logic       v_carry;
        logic [3:0] v_digit;
        w_stepped = r_count;
        v_carry   = 1'b1;
        v_digit   = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            v_digit = r_count[4*k +: 4];
            if (up) begin
                if (v_carry) begin
                    w_stepped[4*k +: 4] = (v_digit == MAX_DIGIT) ? 4'd0 : v_digit + 4'd1;
                end
                v_carry = v_carry && (v_digit == MAX_DIGIT);
            end else begin
                if (v_carry) begin
                    w_stepped[4*k +: 4] = (v_digit == 4'd0) ? MAX_DIGIT : v_digit - 4'd1;
                end
                v_carry = v_carry && (v_digit == 4'd0);
            end
        end
        w_boundary = v_carry;
    end

    always_comb begin
        logic [3:0] v_ld;
        w_load = '0;
        v_ld   = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            v_ld = load_value[4*k +: 4];
            w_load[4*k +: 4] = ({1'b0, v_ld} >= 5'(MODULUS)) ? 4'd0 : v_ld;
        end
    end

    always_comb begin
        w_at_max = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_count[4*k +: 4] != MAX_DIGIT) begin
                w_at_max = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= '0;
            r_rollover <= 1'b0;
        end else if (load) begin
            r_count    <= w_load;
            r_rollover <= 1'b0;
        end else if (enable) begin
            // Saturating mode keeps the end value but still reports the boundary hit.
            if (w_boundary && (WRAP == 0)) begin
                r_count <= r_count;
            end else begin
                r_count <= w_stepped;
            end
            r_rollover <= w_boundary;
        end else begin
            r_rollover <= 1'b0;
        end
    end

    assign count    = r_count;
    assign rollover = r_rollover;
    assign at_max   = w_at_max;
    assign at_zero  = (r_count == '0);

endmodule

// File: tb/tb_bcd_counter_cascade.sv
// tb/tb_bcd_counter_cascade.sv - checks three 2-digit counter variants against an integer model
module tb_bcd_counter_cascade;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       up = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_value = 8'h00;

    logic [7:0] cnt [3];
    logic       roll [3];
    logic       amax [3];
    logic       azero [3];

    int n_checks = 0;
    int n_fail   = 0;

    int m_val [3];
    int m_roll [3];
    int m_mod [3]  = '{10, 10, 16};
    int m_wrap [3] = '{1, 0, 1};

    always #5 clk = ~clk;

    bcd_counter_cascade #(.DIGITS(2), .MODULUS(10), .WRAP(1)) u_dec_wrap (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_value(load_value), .count(cnt[0]), .rollover(roll[0]),
        .at_max(amax[0]), .at_zero(azero[0]));

    bcd_counter_cascade #(.DIGITS(2), .MODULUS(10), .WRAP(0)) u_dec_sat (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_value(load_value), .count(cnt[1]), .rollover(roll[1]),
        .at_max(amax[1]), .at_zero(azero[1]));

    bcd_counter_cascade #(.DIGITS(2), .MODULUS(16), .WRAP(1)) u_hex_wrap (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
        .load_value(load_value), .count(cnt[2]), .rollover(roll[2]),
        .at_max(amax[2]), .at_zero(azero[2]));

    function automatic logic [7:0] to_digits(input int val, input int md);
        logic [7:0] r;
        r[3:0] = 4'(val % md);
        r[7:4] = 4'(val / md);
        return r;
    endfunction

    function automatic int legal(input int d, input int md);
        return (d >= md) ? 0 : d;
    endfunction

    task automatic model_update();
        int mx;
        for (int i = 0; i < 3; i++) begin
            mx = m_mod[i] * m_mod[i] - 1;
            if (reset) begin
                m_val[i] = 0; m_roll[i] = 0;
            end else if (load) begin
                m_val[i] = legal(int'(load_value[3:0]), m_mod[i])
                         + m_mod[i] * legal(int'(load_value[7:4]), m_mod[i]);
                m_roll[i] = 0;
            end else if (enable && up) begin
                if (m_val[i] == mx) begin
                    m_roll[i] = 1; m_val[i] = m_wrap[i] ? 0 : mx;
                end else begin
                    m_roll[i] = 0; m_val[i] = m_val[i] + 1;
                end
            end else if (enable) begin
                if (m_val[i] == 0) begin
                    m_roll[i] = 1; m_val[i] = m_wrap[i] ? mx : 0;
                end else begin
                    m_roll[i] = 0; m_val[i] = m_val[i] - 1;
                end
            end else begin
                m_roll[i] = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [7:0] exp_cnt;
        logic       exp_max;
        logic       exp_zero;
        logic       exp_roll;
        for (int i = 0; i < 3; i++) begin
            exp_cnt  = to_digits(m_val[i], m_mod[i]);
            exp_max  = (m_val[i] == m_mod[i] * m_mod[i] - 1);
            exp_zero = (m_val[i] == 0);
            exp_roll = (m_roll[i] != 0);
            n_checks++;
            assert (cnt[i] === exp_cnt) else begin
                n_fail++;
                $error("FAIL %s count dut%0d: observed %h expected %h", tag, i, cnt[i], exp_cnt);
            end
            n_checks++;
            assert (roll[i] === exp_roll) else begin
                n_fail++;
                $error("FAIL %s rollover dut%0d: observed %b expected %b", tag, i, roll[i], exp_roll);
            end
            n_checks++;
            assert (amax[i] === exp_max) else begin
                n_fail++;
                $error("FAIL %s at_max dut%0d: observed %b expected %b", tag, i, amax[i], exp_max);
            end
            n_checks++;
            assert (azero[i] === exp_zero) else begin
                n_fail++;
                $error("FAIL %s at_zero dut%0d: observed %b expected %b", tag, i, azero[i], exp_zero);
            end
        end
    endtask

    task automatic step(input logic rs, input logic ld, input logic [7:0] lv,
                        input logic en, input logic dir, input string tag);
        reset = rs; load = ld; load_value = lv; enable = en; up = dir;
        @(posedge clk);
        #1;
        model_update();
        check_all(tag);
    endtask

    initial begin
        step(1, 0, 8'h00, 0, 0, "reset");
        step(0, 0, 8'h00, 0, 0, "idle");

        for (int n = 0; n < 100; n++) step(0, 0, 8'h00, 1, 1, "full_up");
        step(0, 0, 8'h00, 1, 1, "post_wrap");

        step(0, 1, 8'h00, 0, 0, "load_zero");
        step(0, 0, 8'h00, 1, 0, "down_wrap");
        step(0, 0, 8'h00, 1, 0, "down_after");

        step(0, 1, 8'h99, 0, 0, "load_99");
        for (int n = 0; n < 3; n++) step(0, 0, 8'h00, 1, 1, "sat_up");
        step(0, 1, 8'h00, 0, 0, "load_00");
        for (int n = 0; n < 3; n++) step(0, 0, 8'h00, 1, 0, "sat_down");

        step(0, 1, 8'hA7, 0, 0, "illegal_a7");
        step(0, 1, 8'hFF, 0, 0, "illegal_ff");
        step(0, 0, 8'h00, 1, 1, "hex_max_up");

        step(0, 1, 8'h99, 0, 0, "prio_setup");
        step(0, 1, 8'h42, 1, 1, "load_beats_en");
        step(1, 1, 8'h42, 1, 1, "reset_beats_load");

        step(0, 1, 8'h50, 0, 0, "mid_setup");
        for (int n = 0; n < 7; n++) step(0, 0, 8'h00, 1, 1, "mid_up");
        step(1, 0, 8'h00, 1, 1, "mid_reset");
        step(0, 0, 8'h00, 1, 1, "resume");

        step(0, 0, 8'h00, 0, 0, "up_toggle0");
        step(0, 0, 8'h00, 0, 1, "up_toggle1");

        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
                 8'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_counter_cascade.md
# bcd_counter_cascade

Parametrised multi-digit cascaded counter. Each digit counts modulo `MODULUS`, and carries or borrows ripple across digits within a single clock. The block adds up/down counting, parallel load, a wrap or saturate mode at the range ends, and end-of-range flags. It is the general counter for timer, stopwatch and display-driving datapaths, feeding per-digit 4-bit values to 7-segment decoders.

## Interface
Parameters:
- `DIGITS`, default 4: number of cascaded digits, 1..8.
- `MODULUS`, default 10: radix of every digit, 2..16.
- `WRAP`, default 1: overflow/underflow policy. 1 = wrap around; 0 = saturate (hold).

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: synchronous, active-high; clears all state.
- `enable`  in  1: when high, the counter advances one step this cycle.
- `up`  in  1: direction. 1 = increment, 0 = decrement. Sampled only when `enable` = 1.
- `load`  in  1: parallel-load strobe.
- `load_value`  in  4*DIGITS: load data; digit k occupies bits [4k+3:4k].
- `count`  out  4*DIGITS: registered count; digit 0 is least significant, at bits [3:0].
- `rollover`  out  1: registered one-cycle pulse marking a boundary event.
- `at_max`  out  1: decode of `count`; high when every digit equals MODULUS-1.
- `at_zero`  out  1: decode of `count`; high when every digit equals 0.

## Operation
- Priority per edge: `reset` > `load` > `enable`. With none of them asserted, `count` holds.
- Reset: `count` = 0 and `rollover` = 0. Consequently `at_zero` = 1 and `at_max` = 0 (for MODULUS ≥ 2).
- Load: each digit takes its `load_value` digit. A digit value ≥ MODULUS is illegal and loads as 0; the other digits load normally. `rollover` = 0 on a load cycle. `enable` is ignored on that cycle.
- Count up (`enable`=1, `up`=1):
  - Digit 0 increments.
  - Digit k>0 increments only when digits 0..k-1 all equal MODULUS-1.
  - Any digit at MODULUS-1 that receives a carry becomes 0.
- Count down (`enable`=1, `up`=0):
  - Digit 0 decrements.
  - Digit k>0 decrements only when digits 0..k-1 all equal 0.
  - Any digit at 0 that receives a borrow becomes MODULUS-1.
- Overflow is an up step taken while `at_max` = 1:
  - WRAP=1: `count` becomes all zeros.
  - WRAP=0: `count` holds at max.
  - Both modes: `rollover` = 1 on the next cycle.
- Underflow is a down step taken while `at_zero` = 1:
  - WRAP=1: `count` becomes all digits MODULUS-1.
  - WRAP=0: `count` holds at zero.
  - Both modes: `rollover` = 1 on the next cycle.
- `rollover` = 0 after every other edge. It never stays high longer than one cycle per event; back-to-back boundary steps give consecutive pulses.
- Width rules:
  - The carry/borrow chain is combinational across all DIGITS.
  - Digit arithmetic is 4-bit; a legal digit never exceeds MODULUS-1.
  - For MODULUS=16, a digit wraps naturally between 15 and 0.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on `count` and `rollover` after edge N.
- `at_max` and `at_zero` are combinational from registered `count`, so they are valid in the same cycle as `count`.
- `rollover` is aligned with the post-event `count`. In wrap mode the pulse coincides with the first cycle showing the wrapped value.
- Reset mid-count: the cycle after reset shows `count` = 0 and `rollover` = 0, even if a boundary event would have fired.
- Simultaneous `load` and boundary `enable`: the load wins and no `rollover` pulse is produced.
- A change on `up` with `enable` = 0 has no effect.

## Test plan
- Full range up, DIGITS=2, MODULUS=10, WRAP=1: reset, then 100 enabled up steps.
  - `count` walks 0x00..0x99, then 0x00; 0x09→0x10 and 0x99→0x00 cross correctly.
  - `rollover` is high for exactly one cycle, together with 0x00.
- Down wrap: load 0x00, then one down step.
  - `count`=0x99, `rollover`=1 for one cycle, `at_max`=1.
  - A further step gives 0x98 and `rollover`=0.
- Saturate, WRAP=0: load 0x99, then 3 up steps.
  - `count` stays 0x99 and `rollover` pulses on each of the 3 cycles.
  - Then 3 down steps from 0x00: `count` stays 0x00 with 3 pulses.
- Illegal load, MODULUS=10: load 0xA7.
  - `count`=0x07.
  - With MODULUS=16, the same load gives 0xA7.
- Priority:
  - Assert `load`=1 (value 0x42) and `enable`=1 together at 0x99 → `count`=0x42, no `rollover`.
  - Assert `reset` with `load`=1 → `count`=0x00.
- Reset mid-operation: count up to 0x57, assert `reset` for 1 cycle with `enable`=1.
  - `count`=0x00, `at_zero`=1.
  - Counting resumes at 0x01 on the next enabled edge.
